// File: rtl/sdram_burst_pkg.sv
// sdram_burst_pkg: shared widths, state encoding and word-order convention for the burst responder
package sdram_burst_pkg;
    localparam int ADDR_W = 25;
    localparam int LEN_W = 11;
    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
    // Burst word order: the even-index word sits in the high half of a 32-bit beat.
    function automatic logic [31:0] pack_words(input logic [15:0] even_word, input logic [15:0] odd_word);
        return {even_word, odd_word};
    endfunction
endpackage

// File: rtl/sdram_burst_responder_if.sv
// sdram_burst_responder_if: scanout burst request/return signals plus the SDRAM controller word port
interface sdram_burst_responder_if;
    import sdram_burst_pkg::*;
    logic              burst_rd;
    logic [ADDR_W-1:0] burst_addr;
    logic [LEN_W-1:0]  burst_len;
    logic              burst_32bit;
    logic [31:0]       burst_data;
    logic              burst_data_valid;
    logic              burst_data_done;
    logic              busy;
    logic              mem_rd;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ack;
    logic [15:0]       mem_rdata;
    logic              mem_rdata_valid;
    modport slave (
        input  burst_rd, burst_addr, burst_len, burst_32bit, mem_ack, mem_rdata, mem_rdata_valid,
        output burst_data, burst_data_valid, burst_data_done, busy, mem_rd, mem_addr
    );
    modport master (
        output burst_rd, burst_addr, burst_len, burst_32bit, mem_ack, mem_rdata, mem_rdata_valid,
        input  burst_data, burst_data_valid, burst_data_done, busy, mem_rd, mem_addr
    );
endinterface

// File: rtl/halfword_packer.sv
// halfword_packer: turns returned 16-bit words into registered beats, flushing an odd tail in 32-bit mode
module halfword_packer
    import sdram_burst_pkg::*;
(
    input  logic        clk_sdram,
    input  logic        reset,
    input  logic        start,
    input  logic        mode32,
    input  logic        word_valid,
    input  logic        word_last,
    input  logic [15:0] word,
    output logic [31:0] beat,
    output logic        beat_valid
);
    logic [15:0] held;
    logic        odd;
    logic        emit;
    assign emit = word_valid && (!mode32 || odd || word_last);
    // Hold even words; emit on the odd partner, on a lone final word, or on every word in 16-bit mode.
    always_ff @(posedge clk_sdram or posedge reset) begin
        if (reset) begin
            held <= '0;
            odd <= 1'b0;
            beat <= '0;
            beat_valid <= 1'b0;
        end else begin
            beat_valid <= emit;
            if (start)
                odd <= 1'b0;
            else if (word_valid)
                odd <= ~odd;
            if (word_valid && !odd)
                held <= word;
            if (emit)
                beat <= !mode32 ? {16'h0, word} : odd ? pack_words(held, word) : pack_words(word, 16'h0);
        end
    end
endmodule

// File: rtl/sdram_burst_responder.sv
// sdram_burst_responder: issues sequential word reads for a scanout burst and returns the data as beats
module sdram_burst_responder
    import sdram_burst_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 4
) (
    input logic clk_sdram,
    input logic reset,
    sdram_burst_responder_if.slave bus
);
    localparam int OW = $clog2(MAX_OUTSTANDING + 1);
    state_t            state;
    state_t            state_n;
    logic [ADDR_W-1:0] addr;
    logic [LEN_W-1:0]  issue_cnt;
    logic [LEN_W-1:0]  ret_cnt;
    logic [OW-1:0]     outstanding;
    logic              mode32;
    logic              accept;
    logic              ack;
    logic              rv;
    assign accept = state == IDLE && bus.burst_rd;
    assign ack = bus.mem_rd && bus.mem_ack;
    assign rv = bus.mem_rdata_valid && (state == ISSUE || state == DRAIN);
    assign bus.mem_rd = state == ISSUE && outstanding < OW'(MAX_OUTSTANDING);
    assign bus.mem_addr = addr;
    assign bus.busy = state != IDLE;
    assign bus.burst_data_done = state == DONE;
    // Next state; a zero-length burst passes through DRAIN so its done pulse lands two cycles after the request.
    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:  if (bus.burst_rd) state_n = bus.burst_len != '0 ? ISSUE : DRAIN;
            ISSUE: if (ack && issue_cnt == LEN_W'(1)) state_n = DRAIN;
            DRAIN: if (ret_cnt == '0) state_n = DONE;
            DONE:  state_n = IDLE;
        endcase
    end
    // State, request address, issue/return counters and in-flight count.
    always_ff @(posedge clk_sdram or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            addr <= '0;
            issue_cnt <= '0;
            ret_cnt <= '0;
            outstanding <= '0;
            mode32 <= 1'b0;
        end else begin
            state <= state_n;
            outstanding <= outstanding + OW'(ack) - OW'(rv);
            if (accept) begin
                addr <= bus.burst_addr;
                issue_cnt <= bus.burst_len;
                ret_cnt <= bus.burst_len;
                mode32 <= bus.burst_32bit;
            end else begin
                if (ack) begin
                    addr <= addr + ADDR_W'(1);
                    issue_cnt <= issue_cnt - LEN_W'(1);
                end
                if (rv)
                    ret_cnt <= ret_cnt - LEN_W'(1);
            end
        end
    end
    halfword_packer u_packer (
        .clk_sdram  (clk_sdram),
        .reset      (reset),
        .start      (accept),
        .mode32     (mode32),
        .word_valid (rv),
        .word_last  (ret_cnt == LEN_W'(1)),
        .word       (bus.mem_rdata),
        .beat       (bus.burst_data),
        .beat_valid (bus.burst_data_valid)
    );
endmodule

// File: tb/tb_sdram_burst_responder.sv
// tb_sdram_burst_responder: table-driven and randomized bursts checked against a burst-level model
module tb_sdram_burst_responder;
    import sdram_burst_pkg::*;
    localparam int MAXO = 4;
    typedef struct {
        logic [ADDR_W-1:0] addr;
        int                len;
        bit                m32;
        int                lat;
        int                stall;
        bit                poke;
        int                beats;
    } vec_t;
    logic clk_sdram = 1'b0;
    logic reset = 1'b1;
    int checks = 0;
    int fails = 0;
    int cyc = 0;
    int lat = 1;
    int stall_pct = 0;
    int outst = 0;
    int max_outst = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int last_valid_cyc = 0;
    bit both = 1'b0;
    bit stray = 1'b0;
    logic [15:0] salt = 16'h0;
    logic [ADDR_W-1:0] issued_q[$];
    int due_q[$];
    logic [15:0] word_q[$];
    logic [31:0] beat_q[$];
    vec_t tbl[8];
    vec_t rv;

    sdram_burst_responder_if bus();
    sdram_burst_responder #(.MAX_OUTSTANDING(MAXO)) dut (
        .clk_sdram (clk_sdram),
        .reset     (reset),
        .bus       (bus)
    );

    always #5 clk_sdram = ~clk_sdram;
    always @(posedge clk_sdram) cyc <= cyc + 1;

    function automatic logic [15:0] fw(input logic [ADDR_W-1:0] x);
        return x[15:0] ^ {7'b0, x[24:16]} ^ salt;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    // SDRAM controller model: random accept stalls, in-order returns after a fixed latency.
    initial begin
        bus.mem_ack = 1'b0;
        bus.mem_rdata = '0;
        bus.mem_rdata_valid = 1'b0;
        forever begin
            @(negedge clk_sdram);
            bus.mem_rdata_valid = 1'b0;
            if (reset) begin
                due_q.delete();
                word_q.delete();
                outst = 0;
            end else begin
                if (due_q.size() > 0 && due_q[0] <= cyc) begin
                    void'(due_q.pop_front());
                    bus.mem_rdata = word_q.pop_front();
                    bus.mem_rdata_valid = 1'b1;
                    outst--;
                end else if (stray) begin
                    bus.mem_rdata = 16'hBEEF;
                    bus.mem_rdata_valid = 1'b1;
                end
                bus.mem_ack = $urandom_range(99) >= stall_pct;
                if (bus.mem_rd && bus.mem_ack) begin
                    issued_q.push_back(bus.mem_addr);
                    due_q.push_back(cyc + lat);
                    word_q.push_back(fw(bus.mem_addr));
                    outst++;
                    if (outst > max_outst) max_outst = outst;
                end
            end
        end
    end

    // Beat and done monitor.
    initial forever begin
        @(negedge clk_sdram);
        if (bus.burst_data_valid) begin
            beat_q.push_back(bus.burst_data);
            last_valid_cyc = cyc;
        end
        if (bus.burst_data_done) begin
            done_cnt++;
            done_cyc = cyc;
            if (bus.burst_data_valid) both = 1'b1;
        end
    end

    task automatic run_burst(input vec_t v);
        logic [31:0] exp_b[$];
        logic [15:0] w[$];
        logic [15:0] lo;
        int guard = 0;
        int req_cyc;
        @(negedge clk_sdram);
        lat = v.lat;
        stall_pct = v.stall;
        salt = 16'($urandom);
        issued_q.delete();
        beat_q.delete();
        done_cnt = 0;
        both = 1'b0;
        max_outst = 0;
        bus.burst_rd = 1'b1;
        bus.burst_addr = v.addr;
        bus.burst_len = LEN_W'(v.len);
        bus.burst_32bit = v.m32;
        req_cyc = cyc;
        @(negedge clk_sdram);
        bus.burst_rd = 1'b0;
        check("busy_rise", 32'(bus.busy), 32'd1);
        check("first_mem_rd", 32'(bus.mem_rd), 32'(v.len != 0));
        if (v.len != 0) check("first_mem_addr", 32'(bus.mem_addr), 32'(v.addr));
        while (!bus.burst_data_done && guard < 5000) begin
            if (v.poke && guard == 2) begin
                bus.burst_rd = 1'b1;
                bus.burst_addr = ~v.addr;
                bus.burst_len = 11'd7;
                bus.burst_32bit = ~v.m32;
            end else begin
                bus.burst_rd = 1'b0;
            end
            @(negedge clk_sdram);
            guard++;
        end
        bus.burst_rd = 1'b0;
        check("done_seen", 32'(bus.burst_data_done), 32'd1);
        @(negedge clk_sdram);
        check("busy_fall", 32'(bus.busy), 32'd0);
        check("done_pulses", 32'(done_cnt), 32'd1);
        check("done_with_valid", 32'(both), 32'd0);
        if (v.len == 0) check("zero_len_done_latency", 32'(done_cyc - req_cyc), 32'd2);
        else check("done_after_last_valid", 32'(done_cyc - last_valid_cyc), 32'd1);
        for (int i = 0; i < v.len; i++) w.push_back(fw(ADDR_W'(v.addr + i)));
        check("issue_count", 32'(issued_q.size()), 32'(v.len));
        for (int i = 0; i < v.len && i < issued_q.size(); i++)
            check("mem_addr_seq", 32'(issued_q[i]), 32'(ADDR_W'(v.addr + i)));
        for (int i = 0; i < v.len; i += (v.m32 ? 2 : 1)) begin
            lo = 16'h0;
            if (i + 1 < v.len) lo = w[i + 1];
            exp_b.push_back(v.m32 ? {w[i], lo} : {16'h0, w[i]});
        end
        check("beat_count", 32'(beat_q.size()), 32'(v.beats));
        for (int i = 0; i < exp_b.size() && i < beat_q.size(); i++)
            check("beat_data", beat_q[i], exp_b[i]);
        check("outstanding_limit", 32'(max_outst <= MAXO), 32'd1);
        if (v.stall == 0 && v.len >= MAXO)
            check("outstanding_fill", 32'(max_outst), 32'(v.lat < MAXO ? v.lat : MAXO));
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        tbl[0] = '{25'h1000,    320, 1'b1, 3,  0,  1'b0, 160};
        tbl[1] = '{25'h0123,    5,   1'b1, 2,  0,  1'b0, 3};
        tbl[2] = '{25'h0200,    4,   1'b0, 10, 40, 1'b0, 4};
        tbl[3] = '{25'h0200,    16,  1'b0, 10, 0,  1'b0, 16};
        tbl[4] = '{25'h0777,    0,   1'b1, 1,  0,  1'b0, 0};
        tbl[5] = '{25'h1FFFFFE, 4,   1'b1, 1,  0,  1'b0, 2};
        tbl[6] = '{25'h0040,    9,   1'b0, 4,  20, 1'b1, 9};
        tbl[7] = '{25'h0080,    1,   1'b1, 1,  0,  1'b0, 1};
        bus.burst_rd = 1'b0;
        bus.burst_addr = '0;
        bus.burst_len = '0;
        bus.burst_32bit = 1'b0;
        repeat (3) @(negedge clk_sdram);
        check("reset_busy", 32'(bus.busy), 32'd0);
        check("reset_mem_rd", 32'(bus.mem_rd), 32'd0);
        check("reset_mem_addr", 32'(bus.mem_addr), 32'd0);
        check("reset_valid", 32'(bus.burst_data_valid), 32'd0);
        check("reset_done", 32'(bus.burst_data_done), 32'd0);
        check("reset_data", bus.burst_data, 32'd0);
        reset = 1'b0;
        for (int t = 0; t < 8; t++) run_burst(tbl[t]);
        // Stray return strobes while idle must not produce beats or disturb the next burst.
        @(negedge clk_sdram);
        beat_q.delete();
        stray = 1'b1;
        repeat (3) @(negedge clk_sdram);
        stray = 1'b0;
        repeat (2) @(negedge clk_sdram);
        check("stray_ignored", 32'(beat_q.size()), 32'd0);
        run_burst('{25'h0500, 3, 1'b1, 2, 0, 1'b0, 2});
        // Reset in the middle of a burst clears every output at once.
        @(negedge clk_sdram);
        lat = 3;
        stall_pct = 0;
        bus.burst_rd = 1'b1;
        bus.burst_addr = 25'h345;
        bus.burst_len = 11'd64;
        bus.burst_32bit = 1'b1;
        @(negedge clk_sdram);
        bus.burst_rd = 1'b0;
        repeat (10) @(negedge clk_sdram);
        check("pre_reset_busy", 32'(bus.busy), 32'd1);
        reset = 1'b1;
        #1;
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_mem_rd", 32'(bus.mem_rd), 32'd0);
        check("abort_mem_addr", 32'(bus.mem_addr), 32'd0);
        check("abort_valid", 32'(bus.burst_data_valid), 32'd0);
        check("abort_done", 32'(bus.burst_data_done), 32'd0);
        check("abort_data", bus.burst_data, 32'd0);
        repeat (2) @(negedge clk_sdram);
        reset = 1'b0;
        run_burst('{25'h0900, 6, 1'b1, 3, 10, 1'b0, 3});
        for (int r = 0; r < 12; r++) begin
            rv.addr = ($urandom_range(3) == 0) ? ADDR_W'(25'h1FFFFF0 + $urandom_range(15)) : ADDR_W'($urandom);
            rv.len = int'($urandom_range(40));
            rv.m32 = 1'($urandom_range(1));
            rv.lat = int'($urandom_range(8, 1));
            rv.stall = int'($urandom_range(60));
            rv.poke = $urandom_range(3) == 0;
            rv.beats = rv.m32 ? (rv.len + 1) / 2 : rv.len;
            run_burst(rv);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
